adc_result_fifo: RTL
====================

ADC_RESULT_FIFO -- requirements
Module: adc_result_fifo

Interface
REQ-001 Parameter DEPTH, default 8, number of result entries; SHALL be a power of two, 2..64.
REQ-002 Parameter COUNT_W, default 32, width of one integration count.
REQ-003 Parameter SEQ_W, default 8, width of the per-conversion sequence tag.
REQ-004 clk  in  1  sole clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous to clk, active-high.
REQ-006 wr_valid  in  1  one-cycle pulse per completed rundown, from the conversion controller.
REQ-007 wr_count  in  COUNT_W  integration count; sampled only when wr_valid=1.
REQ-008 rd_pop  in  1  one-cycle pulse from the SPI side; consumes the head entry.
REQ-009 clr_ovf  in  1  one-cycle pulse; clears overflow and drop_cnt.
REQ-010 rd_valid  out  1  FIFO non-empty; rd_count and rd_seq are meaningful.
REQ-011 rd_count  out  COUNT_W  head entry count (first-word-fall-through).
REQ-012 rd_seq  out  SEQ_W  head entry sequence tag.
REQ-013 level  out  log2(DEPTH)+1  current number of stored entries.
REQ-014 overflow  out  1  sticky; a result was dropped because the FIFO was full.
REQ-015 drop_cnt  out  8  number of dropped results; saturates at 255.

Function
REQ-016 The block SHALL keep a tag counter seq, SEQ_W bits, that increments by 1 on every wr_valid pulse, whether accepted or dropped, and wraps from all-ones to 0.
REQ-017 Each accepted entry SHALL store {wr_count, seq value before increment}, so the first result after reset carries tag 0.
REQ-018 Push: wr_valid=1 and (level<DEPTH or rd_pop=1 with level=DEPTH) SHALL store the entry at the write pointer.
REQ-019 Drop: wr_valid=1, level=DEPTH, rd_pop=0 SHALL discard the entry, set overflow=1, and increment drop_cnt (saturating at 255).
REQ-020 Pop: rd_pop=1 with level>0 SHALL advance the read pointer; rd_pop with level=0 SHALL be ignored and SHALL NOT change any state.
REQ-021 Simultaneous push and pop SHALL leave level unchanged; when level=0, pop SHALL be ignored and push SHALL proceed (level becomes 1).
REQ-022 An entry pushed in cycle N SHALL appear on rd_count/rd_seq with rd_valid=1 in cycle N+1 when the FIFO was empty.
REQ-023 After a pop in cycle N, rd_count/rd_seq SHALL present the next entry in cycle N+1, or rd_valid=0 if the FIFO is empty.
REQ-024 level, rd_valid, overflow and drop_cnt SHALL be registered outputs that update one cycle after the causing event.
REQ-025 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; full/empty SHALL derive from level, not from pointer equality.
REQ-026 clr_ovf=1 SHALL zero overflow and drop_cnt; if a drop occurs in the same cycle, overflow SHALL be 1 and drop_cnt SHALL be 1.
REQ-027 rd_count/rd_seq SHALL hold their last value while rd_valid=0; consumers SHALL ignore them in that state.

Reset
REQ-028 rst=1 SHALL, on the next clock edge, set pointers, level, seq, overflow and drop_cnt to 0 and rd_valid to 0; storage contents are don't-care.
REQ-029 rst SHALL take priority over wr_valid, rd_pop and clr_ovf in the same cycle; all stored entries are discarded.
REQ-030 The first wr_valid after rst deasserts SHALL be accepted with tag 0.

Structure
REQ-031 Package adc_pkg SHALL hold COUNT_W, SEQ_W, the default FIFO depth and the result-entry struct {count, seq}; the conversion controller and SPI slave SHALL use the same package.
REQ-032 Storage SHALL be one sub-module, fifo_mem (DEPTH x (COUNT_W+SEQ_W), one write port, one asynchronous read port); pointer, level and flag logic SHALL stay in adc_result_fifo.

Verification
REQ-033 After reset, push counts 100, 200, 300 on separate cycles and then pop three times: outputs SHALL be (100,0), (200,1), (300,2); afterwards rd_valid=0 and level=0.
REQ-034 Push 8 entries (DEPTH=8), then push 0xDEAD: the FIFO SHALL report level=8, overflow=1 and drop_cnt=1, the head entry SHALL keep tag 0, and the next accepted push SHALL carry tag 9.
REQ-035 With level=8, assert push 0x55 and pop in the same cycle: the FIFO SHALL report level=8 and overflow=0, and the tail entry SHALL be 0x55.
REQ-036 Pop with level=0, and pop together with push while empty: the first SHALL cause no state change; the second SHALL leave level=1 with the pushed entry at the head.
REQ-037 Cause 300 drops: drop_cnt SHALL saturate at 255; clr_ovf together with one more drop SHALL give overflow=1 and drop_cnt=1; clr_ovf alone SHALL give 0 and 0.
REQ-038 Push 256 results with interleaved pops: tags SHALL wrap 255 to 0; assert rst while level=5 and push 7 on the next cycle: the FIFO SHALL give level=1 and head (7,0).

Source files
------------

// File: rtl/adc_pkg.sv
// ============================================================================
// Module      : adc_pkg
// Description : Shared widths, default depth and result-entry type for the
//               ADC conversion path (controller, result FIFO, SPI slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_pkg;

    localparam int c_count_w    = 32;
    localparam int c_seq_w      = 8;
    localparam int c_fifo_depth = 8;

    typedef struct packed {
        logic [c_count_w-1:0] count;
        logic [c_seq_w-1:0]   seq;
    } adc_result_t;

endpackage : adc_pkg

`default_nettype wire

// File: rtl/fifo_mem.sv
// ============================================================================
// Module      : fifo_mem
// Description : Result storage array; one synchronous write port and one
//               asynchronous read port. No reset on the array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_mem
    import adc_pkg::*;
#(
    parameter int DEPTH = c_fifo_depth,
    parameter int WIDTH = c_count_w + c_seq_w
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule : fifo_mem

`default_nettype wire

// File: rtl/adc_result_fifo.sv
// ============================================================================
// Module      : adc_result_fifo
// Description : First-word-fall-through FIFO of tagged ADC integration counts
//               with sticky overflow flag and saturating drop counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_result_fifo
    import adc_pkg::*;
#(
    parameter int DEPTH   = c_fifo_depth,
    parameter int COUNT_W = c_count_w,
    parameter int SEQ_W   = c_seq_w
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_valid,
    input  logic [COUNT_W-1:0]     wr_count,
    input  logic                   rd_pop,
    input  logic                   clr_ovf,
    output logic                   rd_valid,
    output logic [COUNT_W-1:0]     rd_count,
    output logic [SEQ_W-1:0]       rd_seq,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [7:0]             drop_cnt
);

    localparam int c_addr_w  = $clog2(DEPTH);
    localparam int c_level_w = c_addr_w + 1;
    localparam int c_entry_w = COUNT_W + SEQ_W;

    localparam logic [c_level_w-1:0] c_full     = c_level_w'(DEPTH);
    localparam logic [c_level_w-1:0] c_level_1  = c_level_w'(1);
    localparam logic [c_addr_w-1:0]  c_ptr_1    = c_addr_w'(1);
    localparam logic [7:0]           c_drop_max = 8'd255;

    logic [c_addr_w-1:0]  r_wr_ptr;
    logic [c_addr_w-1:0]  r_rd_ptr;
    logic [c_level_w-1:0] r_level;
    logic [SEQ_W-1:0]     r_seq;
    logic                 r_rd_valid;
    logic [COUNT_W-1:0]   r_rd_count;
    logic [SEQ_W-1:0]     r_rd_seq;
    logic                 r_overflow;
    logic [7:0]           r_drop_cnt;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_drop;
    logic [c_addr_w-1:0]  w_rd_ptr_nxt;
    logic [c_level_w-1:0] w_level_nxt;
    logic [c_entry_w-1:0] w_wr_entry;
    logic [c_entry_w-1:0] w_mem_rd;
    logic [c_entry_w-1:0] w_head_nxt;

    assign w_full  = (r_level == c_full);
    assign w_empty = (r_level == '0);

    // A pop on a full FIFO frees the slot the simultaneous write lands in.
    assign w_pop  = rd_pop & ~w_empty;
    assign w_push = wr_valid & (~w_full | rd_pop);
    assign w_drop = wr_valid & w_full & ~rd_pop;

    assign w_wr_entry   = {wr_count, r_seq};
    assign w_rd_ptr_nxt = w_pop ? (r_rd_ptr + c_ptr_1) : r_rd_ptr;

    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + c_level_1;
            2'b01:   w_level_nxt = r_level - c_level_1;
            default: w_level_nxt = r_level;
        endcase
    end

    fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (c_entry_w)
    ) u_fifo_mem (
        .clk     (clk),
        .wr_en   (w_push),
        .wr_addr (r_wr_ptr),
        .wr_data (w_wr_entry),
        .rd_addr (w_rd_ptr_nxt),
        .rd_data (w_mem_rd)
    );

    // The next head is the entry being written this cycle when it lands
    // exactly at the next read address (empty push, or level 1 push+pop).
    assign w_head_nxt = (w_push && (r_wr_ptr == w_rd_ptr_nxt)) ? w_wr_entry : w_mem_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_seq      <= '0;
            r_rd_valid <= 1'b0;
            r_rd_count <= '0;
            r_rd_seq   <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_1;
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            r_level  <= w_level_nxt;
            if (wr_valid) begin
                r_seq <= r_seq + 1'b1;
            end

            r_rd_valid <= (w_level_nxt != '0);
            if (w_level_nxt != '0) begin
                {r_rd_count, r_rd_seq} <= w_head_nxt;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
                if (clr_ovf) begin
                    r_drop_cnt <= 8'd1;
                end else if (r_drop_cnt != c_drop_max) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
                r_drop_cnt <= '0;
            end
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_count = r_rd_count;
    assign rd_seq   = r_rd_seq;
    assign level    = r_level;
    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;

endmodule : adc_result_fifo

`default_nettype wire
